iota_rr_scheduler: RTL and testbench
====================================

Name: iota_rr_scheduler

Overview:
Shares one accumulate-and-rotate datapath among NUM_REQ requesters. Each requester has a private accumulator context. Requesters are granted in round-robin order, one burst at a time. The block sits between requester stream sources and a single result stream sink, and returns one tagged result per accepted beat.

Parameters:
WIDTH, 32, data/accumulator width in bits (>=2)
NUM_REQ, 4, number of requesters (>=2)
MAX_BURST, 16, max beats per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester beat valid
req_ready  output  NUM_REQ  per-requester beat accept
req_data  input  NUM_REQ*WIDTH  packed beat data; requester i at [i*WIDTH +: WIDTH]
req_last  input  NUM_REQ  last beat of requester's burst
acc_clr  input  NUM_REQ  per-requester context clear pulse
rsp_valid  output  1  result valid
rsp_ready  input  1  sink accept
rsp_data  output  WIDTH  result word
rsp_id  output  $clog2(NUM_REQ)  requester index of result
rsp_last  output  1  result closes the burst
busy  output  1  high in state BURST

Behaviour:
- Reset values:
  - state IDLE; all acc[i]=0; rr pointer last_grant=NUM_REQ-1; beat_cnt=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_last=0, req_ready=0, busy=0.
- States: IDLE, BURST.
- IDLE:
  - req_ready all 0.
  - If any req_valid: pick the first valid index searching upward from last_grant+1, with wrap.
  - Register it as grant g; go to BURST next cycle; beat_cnt=0.
  - No valid: stay in IDLE.
- BURST:
  - busy=1. Only req_ready[g] may be high.
  - req_ready[g] = !rsp_valid || rsp_ready (single output register, full throughput, no skid).
  - Accept = req_valid[g] && req_ready[g]. On accept:
    - rsp_data <= acc[g] | rotl1(data), where rotl1(x) = {x[WIDTH-2:0], x[WIDTH-1]}.
    - acc[g] <= acc[g] + data, mod 2^WIDTH; carry dropped.
    - rsp_id <= g; rsp_valid <= 1; beat_cnt++.
    - rsp_last <= req_last[g] || beat_cnt==MAX_BURST-1.
  - If that rsp_last condition holds on accept: go to IDLE; last_grant <= g.
  - Latency: accept to rsp_valid is 1 cycle.
  - IDLE to first possible accept is 1 cycle, so there is at least one bubble between bursts.
- Output register:
  - rsp_valid clears on rsp_valid && rsp_ready with no new accept.
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - rsp output drains independently of state, including in IDLE.
- Requester with no valid while granted: the grant is held indefinitely. There is no timeout; MAX_BURST counts accepted beats only.
- acc_clr[i]:
  - Sets acc[i]=0 next cycle, in any state.
  - If simultaneous with an accept for i: the cleared value is used. rsp_data = rotl1(data), and acc[i] <= data.
- Simultaneous req_valid from several requesters: exactly one grant, per rr order. The others wait with ready=0.
- req_valid deasserted by a non-granted requester has no effect.
- rst_n asserted mid-burst: all state returns to reset values immediately. An in-flight rsp beat is dropped.

Decomposition:
- Package iota_pkg:
  - state_t enum {IDLE, BURST}.
  - Function rotl1(logic [WIDTH-1:0]) (package parameter or parameterised class function).
  - Localparam ID_W = $clog2(NUM_REQ) is computed in the module.
- One sub-module, iota_rr_arbiter:
  - Combinational round-robin pick.
  - Inputs: req vector, last_grant. Outputs: grant index, any_req.
- Accumulator bank and FSM stay in the top.

Test Plan:
- Single burst: req0 sends 1, 2, 3 (last on 3), rsp_ready=1 -> rsp_data 0x2, 0x5, 0x7; rsp_id=0; rsp_last on third beat; acc[0]=6; returns to IDLE.
- Rotate wrap: req1 sends 0x80000000 (last), acc[1]=0 -> rsp_data=0x00000001; acc[1]=0x80000000. Next burst sends 0x80000000 -> rsp_data=0x80000001; acc[1]=0 (overflow dropped).
- Round-robin fairness: all four req_valid held high, each burst 1 beat, last=1 -> grant order 0, 1, 2, 3, 0 with one idle cycle between grants.
- Forced re-arbitration: MAX_BURST=16, req2 streams 20 beats with last never set, req3 valid -> rsp_last on beat 16; next grant is req3, not req2.
- Backpressure: rsp_ready=0 for 5 cycles mid-burst -> req_ready[g]=0 after one beat buffered; rsp_data stable; no beat lost or duplicated.
- Clear collision: acc[0]=6, then acc_clr[0] in the same cycle as accept of data 4 -> rsp_data=0x8; acc[0]=4. Async reset mid-burst -> rsp_valid=0 and acc all 0 immediately.

Source files
------------

// File: rtl/iota_rr_scheduler_pkg.sv
// Shared types and helpers for the iota round-robin accumulate scheduler.
package iota_pkg;

    // Two-state grant FSM; the explicit encoding matches the legacy one-bit state register.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Width-parameterised bit helpers, called as iota_bits#(W)::rotl1(x).
    virtual class iota_bits #(parameter int unsigned W = 32);
        static function logic [W-1:0] rotl1(input logic [W-1:0] x);
            return {x[W-2:0], x[W-1]};
        endfunction
    endclass

endpackage

// File: rtl/iota_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first asserted request above last_grant, with wrap.
module iota_rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant,
    output logic               any_req
);

    int unsigned     idx;
    logic [ID_W-1:0] cand;

    // Walk the requesters in rr order starting just after last_grant; keep the first hit.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(last_grant) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
    end

endmodule

// File: rtl/iota_rr_scheduler.sv
// Round-robin scheduler sharing one accumulate-and-rotate datapath among NUM_REQ requesters.
module iota_rr_scheduler
    import iota_pkg::*;
#(
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned MAX_BURST = 16,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ-1:0]       acc_clr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_last,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [WIDTH-1:0]  acc_q [NUM_REQ];
    logic [WIDTH-1:0]  acc_d [NUM_REQ];
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_last_q, rsp_last_d;

    logic [WIDTH-1:0]  data_arr [NUM_REQ];
    logic [WIDTH-1:0]  beat_data;
    logic [WIDTH-1:0]  acc_base;
    logic              slot_free;
    logic              accept;
    logic              burst_end;
    logic [ID_W-1:0]   arb_grant;
    logic              arb_any;

    iota_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    // Unpack the flat requester data bus into one word per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Grant FSM, accumulator bank update and single-entry result register next-state.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_last_d   = rsp_last_q;
        req_ready    = '0;

        beat_data = data_arr[grant_q];
        // A clear landing on the same cycle as an accept wins: the beat sees a zero context.
        acc_base  = acc_clr[grant_q] ? '0 : acc_q[grant_q];
        slot_free = !rsp_valid_q || rsp_ready;
        accept    = (state_q == BURST) && req_valid[grant_q] && slot_free;
        burst_end = req_last[grant_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1));

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            acc_d[i] = acc_clr[i] ? '0 : acc_q[i];
        end

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d    = BURST;
                    grant_d    = arb_grant;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                req_ready[grant_q] = slot_free;
                if (accept) begin
                    acc_d[grant_q] = acc_base + beat_data;
                    rsp_valid_d    = 1'b1;
                    rsp_data_d     = acc_base | iota_bits#(WIDTH)::rotl1(beat_data);
                    rsp_id_d       = grant_q;
                    rsp_last_d     = burst_end;
                    beat_cnt_d     = beat_cnt_q + CNT_W'(1);
                    if (burst_end) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

    // Per-requester accumulator contexts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_iota_rr_scheduler.sv
// Self-checking bench for iota_rr_scheduler: behavioural model plus directed literal checks.
module tb_iota_rr_scheduler;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int MB  = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     acc_clr = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [W-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             rsp_last;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    always #5 clk = ~clk;

    iota_rr_scheduler #(
        .WIDTH     (W),
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .acc_clr   (acc_clr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy  = 0;
    int          m_g     = 0;
    int          m_lastg = N - 1;
    int          m_cnt   = 0;
    logic [31:0] m_acc [N];
    bit          m_rv    = 0;
    bit          m_rl    = 0;
    logic [31:0] m_rd    = '0;
    int          m_rid   = 0;

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << 1) | (x >> 31);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_busy && (!m_rv || rsp_ready)) r[m_g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit          was_busy;
        bit          take;
        logic [31:0] d;
        logic [31:0] base;
        if (!rst_n) begin
            m_busy = 0; m_g = 0; m_lastg = N - 1; m_cnt = 0;
            m_rv = 0; m_rl = 0; m_rd = '0; m_rid = 0;
            for (int i = 0; i < N; i++) m_acc[i] = '0;
        end else begin
            was_busy = m_busy;
            take = m_busy && req_valid[m_g] && (!m_rv || rsp_ready);
            if (!take && m_rv && rsp_ready) m_rv = 0;
            if (take) begin
                d     = req_data[m_g*W +: W];
                base  = acc_clr[m_g] ? 32'd0 : m_acc[m_g];
                m_rd  = base | rotl(d);
                m_rid = m_g;
                m_rv  = 1;
                m_cnt = m_cnt + 1;
                m_rl  = req_last[m_g] || (m_cnt == MB);
                m_acc[m_g] = base + d;
                if (m_rl) begin
                    m_busy  = 0;
                    m_lastg = m_g;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acc_clr[i] && !(take && i == m_g)) m_acc[i] = '0;
            end
            if (!was_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_lastg + k) % N;
                    if (!m_busy && req_valid[j]) begin
                        m_busy = 1;
                        m_g    = j;
                        m_cnt  = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_data", rsp_data, m_rd);
            chk("rsp_id", rsp_id, m_rid);
            chk("rsp_last", rsp_last, m_rl);
            chk("req_ready", req_ready, exp_ready());
            chk("busy", busy, m_busy);
        end
    end

    // Log of results actually handed to the sink.
    logic [31:0] obs_d [$];
    int          obs_id [$];
    bit          obs_l [$];

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            obs_d.push_back(rsp_data);
            obs_id.push_back(int'(rsp_id));
            obs_l.push_back(rsp_last);
        end
    end

    task automatic obs_clear();
        obs_d.delete();
        obs_id.delete();
        obs_l.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 0;
        req_valid = '0;
        req_last  = '0;
        acc_clr   = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        cyc(2);
        rst_n = 1;
    endtask

    // Offer one beat on requester i until accepted; optionally pulse acc_clr on the accept cycle.
    task automatic send_beat(input int i, input logic [31:0] d, input bit last, input bit clr);
        bit got;
        got = 0;
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = d;
        req_last[i]        = last;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1;
                if (clr) acc_clr[i] = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        acc_clr[i]   = 1'b0;
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        chk("beat_accepted", got, 1);
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int c = 0; c < budget && obs_d.size() < n; c++) cyc(1);
        chk("obs_count_reached", obs_d.size() >= n, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        cmp_en = 1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_ready", req_ready, 4'h0);

        // Single burst on req0: 1,2,3
        obs_clear();
        send_beat(0, 32'd1, 0, 0);
        send_beat(0, 32'd2, 0, 0);
        send_beat(0, 32'd3, 1, 0);
        cyc(3);
        chk("t1_d0", obs_d[0], 32'h2);
        chk("t1_d1", obs_d[1], 32'h5);
        chk("t1_d2", obs_d[2], 32'h7);
        chk("t1_id", obs_id[2], 0);
        chk("t1_last_mid", obs_l[1], 0);
        chk("t1_last_end", obs_l[2], 1);
        chk("t1_model_acc0", m_acc[0], 32'd6);
        chk("t1_idle", busy, 0);

        // Clear colliding with accept of 4, then read back context with a zero beat
        send_beat(0, 32'd4, 1, 1);
        send_beat(0, 32'd0, 1, 0);
        cyc(3);
        chk("clr_d", obs_d[3], 32'h8);
        chk("clr_acc_readback", obs_d[4], 32'h4);

        // Rotate wrap and accumulator overflow on req1
        do_reset();
        obs_clear();
        send_beat(1, 32'h8000_0000, 1, 0);
        send_beat(1, 32'h8000_0000, 1, 0);
        send_beat(1, 32'h0, 1, 0);
        cyc(3);
        chk("rot_d0", obs_d[0], 32'h0000_0001);
        chk("rot_d1", obs_d[1], 32'h8000_0001);
        chk("rot_overflow", obs_d[2], 32'h0);
        chk("rot_id", obs_id[1], 1);
        chk("rot_model_acc1", m_acc[1], 32'h0);

        // Round-robin fairness with all requesters valid, one-beat bursts
        do_reset();
        obs_clear();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'(16 * (i + 1));
        req_last  = '1;
        req_valid = '1;
        wait_obs(5, 60);
        chk("rr_0", obs_id[0], 0);
        chk("rr_1", obs_id[1], 1);
        chk("rr_2", obs_id[2], 2);
        chk("rr_3", obs_id[3], 3);
        chk("rr_4", obs_id[4], 0);

        // Forced re-arbitration after MAX_BURST beats
        do_reset();
        obs_clear();
        req_data[2*W +: W] = 32'd1;
        req_data[3*W +: W] = 32'd7;
        req_last  = 4'b1000;
        req_valid = 4'b1100;
        wait_obs(17, 100);
        req_valid = '0;
        chk("force_id15", obs_id[15], 2);
        chk("force_last14", obs_l[14], 0);
        chk("force_last15", obs_l[15], 1);
        chk("force_d15", obs_d[15], 32'hF);
        chk("force_next_id", obs_id[16], 3);
        chk("force_next_d", obs_d[16], 32'hE);

        // Backpressure mid-burst
        do_reset();
        obs_clear();
        fork
            begin
                for (int k = 1; k <= 6; k++) send_beat(0, 32'(k), k == 6, 0);
            end
            begin
                cyc(3);
                rsp_ready = 0;
                cyc(2);
                chk("bp_ready_low", req_ready, 4'h0);
                chk("bp_valid_held", rsp_valid, 1);
                chk("bp_data_held", rsp_data, 32'h5);
                cyc(3);
                rsp_ready = 1;
            end
        join
        cyc(3);
        chk("bp_count", obs_d.size(), 6);
        chk("bp_d0", obs_d[0], 32'h2);
        chk("bp_d1", obs_d[1], 32'h5);
        chk("bp_d2", obs_d[2], 32'h7);
        chk("bp_d3", obs_d[3], 32'hE);
        chk("bp_d4", obs_d[4], 32'hA);
        chk("bp_d5", obs_d[5], 32'hF);
        chk("bp_last", obs_l[5], 1);

        // Asynchronous reset mid-burst with a result stuck in the output register
        do_reset();
        obs_clear();
        rsp_ready = 0;
        req_data[0 +: W] = 32'd5;
        req_valid = 4'b0001;
        cyc(4);
        chk("ar_pre_valid", rsp_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_req_ready", req_ready, 4'h0);
        chk("ar_rsp_data", rsp_data, 32'h0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n     = 1;
        rsp_ready = 1;
        send_beat(0, 32'd0, 1, 0);
        cyc(3);
        chk("ar_acc_cleared", obs_d[0], 32'h0);
        chk("ar_count", obs_d.size(), 1);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
